div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Clock  input  1  rising-edge system clock; the only clock.
REQ-002 Reset  input  1  asynchronous, active-high reset.
REQ-003 State  input  2  control-unit command: 00 idle, 01 load, 10 run, 11 hold.
REQ-004 Dividend  input  32  two's-complement dividend; sampled only in load.
REQ-005 Divisor  input  32  two's-complement divisor; sampled only in load.
REQ-006 Hi  output  32  registered remainder of last completed division.
REQ-007 Lo  output  32  registered quotient of last completed division.
REQ-008 DivtoControl  output  1  registered done flag for the control unit.
REQ-009 DivZero  output  1  registered divide-by-zero flag for the control unit.

Function
REQ-010 The unit SHALL implement signed 32/32 division: quotient truncated toward zero, remainder sign equal to dividend sign, Dividend = Lo*Divisor + Hi.
REQ-011 Idle (00) SHALL clear DivtoControl, DivZero and the iteration counter, and SHALL hold Hi/Lo.
REQ-012 Load (01) SHALL latch the operand magnitudes, quotient sign (Dividend[31] xor Divisor[31]) and remainder sign (Dividend[31]), SHALL clear the counter, partial remainder and DivtoControl, and SHALL set an internal loaded flag.
REQ-013 Load with Divisor == 0 SHALL set DivZero = 1 at that edge and SHALL clear the loaded flag.
REQ-014 Run (10) with the loaded flag set SHALL perform one restoring step per rising edge: shift the partial remainder left by one bit, inserting the next dividend bit; subtract the divisor magnitude if no borrow; shift in the quotient bit.
REQ-015 On the 32nd run edge, the unit SHALL apply the signs, write Lo and Hi, set DivtoControl = 1 and clear the loaded flag, all at that same edge.
REQ-016 Hi/Lo SHALL change only at the REQ-015 completion edge and SHALL never expose intermediate values.
REQ-017 Once set, DivtoControl SHALL stay 1 while State remains 10 or 11, and SHALL clear on idle or load.
REQ-018 Run without the loaded flag (after completion, after a zero-divisor load, or after reset) SHALL perform no step and leave all outputs unchanged.
REQ-019 Hold (11) SHALL freeze the counter, working registers and outputs.
REQ-020 A load during an in-progress run SHALL abort it and restart with the new operands; Hi/Lo SHALL keep their prior values.
REQ-021 0x80000000 / 0xFFFFFFFF SHALL yield Lo = 0x80000000 and Hi = 0, with no flag raised.
REQ-022 Latency SHALL be 1 load edge plus 32 run edges; DivtoControl SHALL be visible in the cycle after the 32nd run edge.

Reset
REQ-023 Reset SHALL asynchronously force Hi = 0, Lo = 0, DivtoControl = 0, DivZero = 0, counter = 0, loaded flag = 0 and all working registers = 0.
REQ-024 Reset asserted mid-division SHALL abandon the operation, and no completion SHALL follow its release.

Structure
REQ-025 A shared package SHALL hold the State encodings (IDLE 2'b00, LOAD 2'b01, RUN 2'b10, HOLD 2'b11), the data width (32) and the iteration count (32).
REQ-026 The package SHALL be shared with the multiplier and the control unit.
REQ-027 One combinational sub-module, div_step, SHALL compute a single restoring iteration: inputs are partial remainder, dividend bit and divisor magnitude; outputs are next remainder and quotient bit.
REQ-028 div_unit SHALL contain the counter, sign handling and output registers.

Verification
REQ-029 Load 100 / 7, then 32 run cycles -> Lo = 0x0000000E, Hi = 0x00000002, DivtoControl rises exactly after run edge 32.
REQ-030 -7 / 2 -> Lo = 0xFFFFFFFD, Hi = 0xFFFFFFFF; 7 / -2 -> Lo = 0xFFFFFFFD, Hi = 0x00000001.
REQ-031 Load 5 / 0, then 40 run cycles -> DivZero = 1 after the load edge, DivtoControl stays 0, Hi/Lo unchanged; idle clears DivZero.
REQ-032 0x80000000 / 0xFFFFFFFF -> Lo = 0x80000000, Hi = 0, DivZero = 0.
REQ-033 Reset pulse at run cycle 10 of 1000 / 3 -> all outputs 0 immediately; further run cycles -> no DivtoControl, Hi = Lo = 0.
REQ-034 State 11 inserted for 5 cycles at run cycle 16 of 1000 / 3 -> completion delayed 5 cycles, Lo = 0x0000014D, Hi = 0x00000001.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the divider, multiplier and control unit:
// command encodings, datapath width and iteration count.
package div_unit_pkg;

  localparam int DATA_W    = 32;
  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    HOLD = 2'b11
  } state_e;

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? -v : v;
  endfunction

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v,
                                                   input logic              neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, then subtract
// the divisor magnitude when that does not borrow.
module div_step
  import div_unit_pkg::*;
(
  input  logic [DATA_W-1:0] rem,
  input  logic              dvd_bit,
  input  logic [DATA_W-1:0] dvs,
  output logic [DATA_W-1:0] next_rem,
  output logic              q_bit
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // The partial remainder stays below the divisor magnitude (<= 2^31), so a
  // 33-bit shift/subtract is enough to see the borrow without overflow.
  always_comb begin
    shifted  = {rem, dvd_bit};
    diff     = shifted - {1'b0, dvs};
    q_bit    = ~diff[DATA_W];
    next_rem = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Signed 32/32 sequential divider driven by control-unit commands; results
// appear on Hi (remainder) and Lo (quotient) only when a division completes.
module div_unit
  import div_unit_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic [1:0]        State,
  input  logic [DATA_W-1:0] Dividend,
  input  logic [DATA_W-1:0] Divisor,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo,
  output logic              DivtoControl,
  output logic              DivZero
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_ITERS - 1);

  logic [DATA_W-1:0] work;
  logic [DATA_W-1:0] dvs_mag;
  logic [DATA_W-1:0] rem;
  logic [CNT_W-1:0]  count;
  logic              q_neg;
  logic              r_neg;
  logic              loaded;

  logic [DATA_W-1:0] next_rem;
  logic              q_bit;
  logic [DATA_W-1:0] next_work;

  div_step u_step (
    .rem      (rem),
    .dvd_bit  (work[DATA_W-1]),
    .dvs      (dvs_mag),
    .next_rem (next_rem),
    .q_bit    (q_bit)
  );

  // work holds the dividend magnitude; quotient bits fill it from the bottom.
  assign next_work = {work[DATA_W-2:0], q_bit};

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      work         <= '0;
      dvs_mag      <= '0;
      rem          <= '0;
      count        <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      loaded       <= 1'b0;
      Hi           <= '0;
      Lo           <= '0;
      DivtoControl <= 1'b0;
      DivZero      <= 1'b0;
    end else begin
      case (state_e'(State))
        IDLE: begin
          DivtoControl <= 1'b0;
          DivZero      <= 1'b0;
          count        <= '0;
        end
        LOAD: begin
          work         <= magnitude(Dividend);
          dvs_mag      <= magnitude(Divisor);
          q_neg        <= Dividend[DATA_W-1] ^ Divisor[DATA_W-1];
          r_neg        <= Dividend[DATA_W-1];
          rem          <= '0;
          count        <= '0;
          DivtoControl <= 1'b0;
          if (Divisor == '0) begin
            DivZero <= 1'b1;
            loaded  <= 1'b0;
          end else begin
            loaded  <= 1'b1;
          end
        end
        RUN: begin
          if (loaded) begin
            work  <= next_work;
            rem   <= next_rem;
            count <= count + CNT_W'(1);
            if (count == LAST_CNT) begin
              Lo           <= apply_sign(next_work, q_neg);
              Hi           <= apply_sign(next_rem, r_neg);
              DivtoControl <= 1'b1;
              loaded       <= 1'b0;
            end
          end
        end
        HOLD: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit with hand-computed results.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [1:0]  State = IDLE;
  logic [31:0] Dividend = '0;
  logic [31:0] Divisor = '0;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        DivtoControl;
  logic        DivZero;

  int total = 0;
  int bad   = 0;

  div_unit dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .State        (State),
    .Dividend     (Dividend),
    .Divisor      (Divisor),
    .Hi           (Hi),
    .Lo           (Lo),
    .DivtoControl (DivtoControl),
    .DivZero      (DivZero)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a command, then advance one rising edge and settle 1ns past it.
  task automatic applyStimulus(input logic [1:0] st, input logic [31:0] dvd,
                               input logic [31:0] dvs, input int cycles);
    State    = st;
    Dividend = dvd;
    Divisor  = dvs;
    for (int i = 0; i < cycles; i++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  // Load, 31 run edges (not yet done, outputs held), then the final edge.
  task automatic divideAndCheck(input string tag, input logic [31:0] dvd,
                                input logic [31:0] dvs, input logic [31:0] prevLo,
                                input logic [31:0] prevHi, input logic [31:0] expLo,
                                input logic [31:0] expHi);
    applyStimulus(LOAD, dvd, dvs, 1);
    applyStimulus(RUN, 32'hDEADBEEF, 32'h0, 31);
    checkOutput({tag, "_done_early"}, 32'(DivtoControl), 32'd0);
    checkOutput({tag, "_lo_held"}, Lo, prevLo);
    checkOutput({tag, "_hi_held"}, Hi, prevHi);
    applyStimulus(RUN, 32'hDEADBEEF, 32'h0, 1);
    checkOutput({tag, "_done"}, 32'(DivtoControl), 32'd1);
    checkOutput({tag, "_lo"}, Lo, expLo);
    checkOutput({tag, "_hi"}, Hi, expHi);
    checkOutput({tag, "_zero"}, 32'(DivZero), 32'd0);
  endtask

  initial begin
    #2;
    checkOutput("rst_hi", Hi, 32'h0);
    checkOutput("rst_lo", Lo, 32'h0);
    checkOutput("rst_done", 32'(DivtoControl), 32'd0);
    checkOutput("rst_zero", 32'(DivZero), 32'd0);
    #10 Reset = 1'b0;
    applyStimulus(IDLE, 32'h0, 32'h0, 2);

    applyStimulus(RUN, 32'h0, 32'h0, 3);
    checkOutput("run_unloaded_done", 32'(DivtoControl), 32'd0);

    divideAndCheck("d100_7", 32'd100, 32'd7, 32'h0, 32'h0, 32'h0000000E, 32'h00000002);
    applyStimulus(HOLD, 32'h0, 32'h0, 2);
    checkOutput("hold_done_sticky", 32'(DivtoControl), 32'd1);
    applyStimulus(RUN, 32'h0, 32'h0, 3);
    checkOutput("rerun_done_sticky", 32'(DivtoControl), 32'd1);
    checkOutput("rerun_lo_kept", Lo, 32'h0000000E);
    applyStimulus(IDLE, 32'h0, 32'h0, 1);
    checkOutput("idle_clears_done", 32'(DivtoControl), 32'd0);
    checkOutput("idle_lo_kept", Lo, 32'h0000000E);

    divideAndCheck("dm7_2", 32'hFFFFFFF9, 32'd2, 32'h0000000E, 32'h00000002,
                   32'hFFFFFFFD, 32'hFFFFFFFF);
    divideAndCheck("d7_m2", 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFF,
                   32'hFFFFFFFD, 32'h00000001);

    applyStimulus(LOAD, 32'd5, 32'd0, 1);
    checkOutput("dz_flag", 32'(DivZero), 32'd1);
    checkOutput("dz_load_clears_done", 32'(DivtoControl), 32'd0);
    applyStimulus(RUN, 32'h0, 32'h0, 40);
    checkOutput("dz_no_done", 32'(DivtoControl), 32'd0);
    checkOutput("dz_lo_kept", Lo, 32'hFFFFFFFD);
    checkOutput("dz_hi_kept", Hi, 32'h00000001);
    checkOutput("dz_flag_held", 32'(DivZero), 32'd1);
    applyStimulus(IDLE, 32'h0, 32'h0, 1);
    checkOutput("dz_idle_clears", 32'(DivZero), 32'd0);

    divideAndCheck("dmin_m1", 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h00000001,
                   32'h80000000, 32'h00000000);
    applyStimulus(IDLE, 32'h0, 32'h0, 1);

    applyStimulus(LOAD, 32'd1000, 32'd3, 1);
    applyStimulus(RUN, 32'h0, 32'h0, 10);
    Reset = 1'b1;
    #1;
    checkOutput("midrst_lo", Lo, 32'h0);
    checkOutput("midrst_hi", Hi, 32'h0);
    checkOutput("midrst_done", 32'(DivtoControl), 32'd0);
    checkOutput("midrst_zero", 32'(DivZero), 32'd0);
    #2 Reset = 1'b0;
    applyStimulus(RUN, 32'h0, 32'h0, 40);
    checkOutput("postrst_done", 32'(DivtoControl), 32'd0);
    checkOutput("postrst_lo", Lo, 32'h0);
    checkOutput("postrst_hi", Hi, 32'h0);

    applyStimulus(LOAD, 32'd1000, 32'd3, 1);
    applyStimulus(RUN, 32'h0, 32'h0, 16);
    applyStimulus(HOLD, 32'h0, 32'h0, 5);
    checkOutput("hold_frozen_done", 32'(DivtoControl), 32'd0);
    applyStimulus(RUN, 32'h0, 32'h0, 15);
    checkOutput("hold_delay_done", 32'(DivtoControl), 32'd0);
    checkOutput("hold_delay_lo", Lo, 32'h0);
    applyStimulus(RUN, 32'h0, 32'h0, 1);
    checkOutput("hold_done", 32'(DivtoControl), 32'd1);
    checkOutput("hold_lo", Lo, 32'h0000014D);
    checkOutput("hold_hi", Hi, 32'h00000001);

    applyStimulus(LOAD, 32'd100, 32'd7, 1);
    applyStimulus(RUN, 32'h0, 32'h0, 10);
    divideAndCheck("abort_9_4", 32'd9, 32'd4, 32'h0000014D, 32'h00000001,
                   32'h00000002, 32'h00000001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
